axi_wr_master: RTL and testbench

- AXI3-style write initiator for the DMA datapath.
- Accepts one burst command (address, length) plus a 64-bit data stream, and issues the AW address phase.
- Drives the W beats with WLAST, then collects the B response.
- One transaction in flight at a time; pairs with the team's AXI write slave on the same AW/W/B channels.

---
 rtl/axi_wr_master_if.sv | 41 ++++
 rtl/axi_wr_master.sv | 142 ++++++++++++++
 tb/tb_axi_wr_master.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_master_if.sv
// AW/W/B channel bundle between the DMA write initiator and an AXI3 write slave.
// The master modport drives address/data and accepts responses; the slave modport is the mirror.
interface axi_wr_master_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWID;

  logic        WVALID;
  logic        WREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic [3:0]  WID;

  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  BID;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST, WID,
    input  WREADY,
    output BREADY,
    input  BVALID, BRESP, BID
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST, WID,
    output WREADY,
    input  BREADY,
    output BVALID, BRESP, BID
  );
endinterface

// File: rtl/axi_wr_master.sv
// AXI3 write initiator: one INCR burst of 64-bit beats per command, with 4KB
// boundary rejection, W pass-through from the data source, and B-response checking.
module axi_wr_master #(
  parameter logic [3:0] AWID = 4'h0,
  parameter logic [1:0] OKAY = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [31:0]            cmd_addr_i,
  input  logic [3:0]             cmd_len_i,
  input  logic                   src_valid_i,
  output logic                   src_ready_o,
  input  logic [63:0]            src_data_i,
  axi_wr_master_if.master        axi,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        cmd_hs;
  logic        w_hs;
  logic [31:0] addr_aligned;
  logic [4:0]  burst_beats;
  logic [12:0] end_offset;
  logic        crosses_4k;

  assign cmd_hs       = cmd_valid_i & cmd_ready_q;
  assign w_hs         = (state_q == DATA) & src_valid_i & axi.WREADY;
  assign addr_aligned = cmd_addr_i & 32'hFFFF_FFF8;
  assign burst_beats  = {1'b0, cmd_len_i} + 5'd1;

  // Byte offset one past the last beat within the 4KB page; anything beyond 4096 spills over.
  assign end_offset   = {1'b0, addr_aligned[11:0]} + {5'b0, burst_beats, 3'b000};
  assign crosses_4k   = (end_offset > 13'd4096);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      len_q       <= 4'h0;
      beat_cnt_q  <= 4'h0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d     = addr_aligned;
          len_d      = cmd_len_i;
          beat_cnt_d = 4'h0;
          if (crosses_4k) begin
            err_d = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (axi.AWREADY) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q == len_q) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (axi.BVALID) begin
          done_d  = 1'b1;
          err_d   = (axi.BRESP != OKAY) || (axi.BID != AWID);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready only after a full cycle spent in IDLE, so it rises the cycle after a return.
    cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  assign axi.AWVALID = (state_q == ADDR);
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = len_q;
  assign axi.AWSIZE  = 3'b011;
  assign axi.AWBURST = 2'b01;
  assign axi.AWID    = AWID;

  assign axi.WVALID  = (state_q == DATA) & src_valid_i;
  assign axi.WDATA   = (state_q == DATA) ? src_data_i : 64'h0;
  assign axi.WSTRB   = 8'hFF;
  assign axi.WLAST   = (state_q == DATA) & src_valid_i & (beat_cnt_q == len_q);
  assign axi.WID     = AWID;
  assign src_ready_o = (state_q == DATA) & axi.WREADY;

  assign axi.BREADY  = (state_q == RESP);

endmodule

// File: tb/tb_axi_wr_master.sv
// Bench for axi_wr_master: directed and random bursts against a transaction-level
// model of the expected AW/W/B traffic, pulses and handshake timing.
module tb_axi_wr_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        src_valid;
  logic        src_ready;
  logic [63:0] src_data;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_wr_master_if axi ();

  axi_wr_master #(.AWID(4'h0), .OKAY(2'b00)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_data_i  (src_data),
    .axi         (axi),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command end to end. w_mode: 0 always ready, 1 toggling, 2 random.
  // s_mode: 0 source always valid, otherwise random gaps. rst_after>0 resets after that many beats.
  task automatic run_txn(input logic [31:0] addr, input int len, input int aw_stall,
                         input int w_mode, input int s_mode, input logic [1:0] bresp,
                         input logic [3:0] bid, input int rst_after);
    logic [63:0] data [16];
    logic [31:0] exp_addr;
    bit reject, exp_err, in_resp, resp_done, exp_busy, pulse_pending;
    bit src_hs, prev_busy, prev_bready, finished, in_data;
    int beats, aw_seen, aw_hs, pulse_cyc;

    for (int i = 0; i < 16; i++) data[i] = {$urandom, $urandom};
    exp_addr = addr & 32'hFFFF_FFF8;
    reject   = (int'(addr & 32'h0000_0FF8) + (len + 1) * 8) > 4096;
    exp_err  = reject || (bresp != 2'b00) || (bid != 4'h0);
    in_resp = 0; resp_done = 0; exp_busy = 0; pulse_pending = 0;
    src_hs = 0; prev_busy = 0; prev_bready = 0; finished = 0;
    beats = 0; aw_seen = 0; aw_hs = 0; pulse_cyc = -1;
    src_valid = 1'b0;
    axi.WREADY = 1'b1;

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (rst_after > 0 && beats == rst_after) begin
        rst = 1'b1;
        #1;
        chk("rst_awvalid", axi.AWVALID, 0);
        chk("rst_wvalid", axi.WVALID, 0);
        chk("rst_wlast", axi.WLAST, 0);
        chk("rst_bready", axi.BREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b0; src_valid = 1'b0; axi.BVALID = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_release_ready", cmd_ready, 1);
        return;
      end

      if (cyc == 0) begin
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 4'(len);
      end else if (prev_busy && !prev_bready && ($urandom_range(0, 3) == 0)) begin
        cmd_valid = 1'b1; cmd_addr = $urandom; cmd_len = 4'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end

      if (src_valid && src_hs) src_valid = 1'b0;
      if (!src_valid && beats <= len)
        src_valid = (s_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      src_data = (beats < 16) ? data[beats] : 64'h0;

      if (w_mode == 0)      axi.WREADY = 1'b1;
      else if (w_mode == 1) axi.WREADY = (cyc == 0) ? 1'b1 : ~axi.WREADY;
      else                  axi.WREADY = 1'($urandom_range(0, 1));
      axi.AWREADY = (aw_seen >= aw_stall);
      axi.BVALID  = in_resp ? 1'b1 : ($urandom_range(0, 7) == 0);
      axi.BRESP   = bresp;
      axi.BID     = bid;

      #1;
      in_data = (aw_hs > 0) && !in_resp && !resp_done;
      if (cyc == 0) chk("cmd_ready_idle", cmd_ready, 1);
      else if (exp_busy) chk("cmd_ready_busy", cmd_ready, 0);
      else if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) chk("cmd_ready_after", cmd_ready, 1);
      chk("busy", busy, exp_busy);
      chk("awvalid", axi.AWVALID, !reject && cyc >= 1 && aw_hs == 0);
      if (axi.AWVALID) begin
        chk("awaddr", axi.AWADDR, exp_addr);
        chk("awlen", axi.AWLEN, len);
        chk("awsize", axi.AWSIZE, 3);
        chk("awburst", axi.AWBURST, 1);
        chk("awid", axi.AWID, 0);
      end
      chk("wvalid", axi.WVALID, in_data && src_valid);
      chk("src_ready", src_ready, in_data && axi.WREADY);
      if (axi.WVALID) begin
        chk("wlast", axi.WLAST, beats == len);
        chk("wdata", axi.WDATA, (beats < 16) ? data[beats] : 64'h0);
        chk("wstrb", axi.WSTRB, 8'hFF);
        chk("wid", axi.WID, 0);
      end
      chk("bready", axi.BREADY, in_resp);
      chk("done", done, pulse_pending && !reject);
      chk("err", err, pulse_pending && exp_err);

      if (pulse_pending) begin
        pulse_cyc = cyc;
        pulse_pending = 0;
        if (!reject && aw_stall == 0 && w_mode == 0 && s_mode == 0)
          chk("latency", cyc, 4 + len);
      end else if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) begin
        finished = 1;
      end
      if (cyc == 0 && cmd_ready) begin
        if (reject) pulse_pending = 1;
        else        exp_busy = 1;
      end
      if (axi.AWVALID && axi.AWREADY) aw_hs++;
      if (axi.AWVALID) aw_seen++;
      if (in_resp && axi.BVALID && axi.BREADY) begin
        in_resp = 0; resp_done = 1; exp_busy = 0; pulse_pending = 1;
      end
      src_hs = src_valid && src_ready;
      if (axi.WVALID && axi.WREADY) begin
        if (beats == len) in_resp = 1;
        beats++;
      end
      prev_busy   = busy;
      prev_bready = axi.BREADY;
    end

    chk("finished", finished, 1);
    if (!reject) chk("beat_total", beats, len + 1);
    else         chk("reject_beats", beats, 0);
    cmd_valid = 1'b0; src_valid = 1'b0; axi.BVALID = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    src_valid = 1'b0; src_data = '0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
    axi.BRESP = 2'b00; axi.BID = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_awvalid", axi.AWVALID, 0);
    chk("reset_wvalid", axi.WVALID, 0);
    chk("reset_bready", axi.BREADY, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_awaddr", axi.AWADDR, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    run_txn(32'h0000_1000, 3, 0, 0, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_2008, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_3000, 5, 5, 1, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_0FF8, 1, 0, 0, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_0F80, 15, 0, 0, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_5F80, 15, 0, 0, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_6FFF, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    run_txn(32'h0000_7000, 2, 0, 0, 0, 2'b10, 4'h0, 0);
    run_txn(32'h0000_8000, 2, 0, 0, 0, 2'b00, 4'h5, 0);
    run_txn(32'h0000_9000, 3, 0, 0, 0, 2'b00, 4'h0, 2);
    run_txn(32'h0000_A000, 3, 0, 0, 0, 2'b00, 4'h0, 0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra;
      logic [1:0]  rb;
      logic [3:0]  rid;
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(ra, $urandom_range(0, 15), $urandom_range(0, 3), 2,
              $urandom_range(0, 1), rb, rid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
